// File: rtl/rangefinder_pkg.sv
// rangefinder_pkg
//   Shared definitions for the rangefinder map-builder link.
//   - Field positions inside the 28-bit data_enable_step word
//     {data[15:0], enable, step[10:0]}; the map builder splits the word
//     with the same constants.
//   - Default angular step limits of one laser scan.
//   - State encoding of the step streamer.
package rangefinder_pkg;

  localparam int DES_DATA_MSB = 27;
  localparam int DES_DATA_LSB = 12;
  localparam int DES_ENABLE   = 11;
  localparam int DES_STEP_MSB = 10;

  localparam int DEF_STEP_FIRST = 44;
  localparam int DEF_STEP_LAST  = 725;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_GAP,
    S_DONE
  } streamer_state_t;

endpackage

// File: rtl/rangefinder_step_streamer.sv
// rangefinder_step_streamer
//   On a rising edge of transmit, walks one laser scan from a sample BRAM and
//   emits one range sample per angular step as a single-cycle enable strobe
//   in data_enable_step, followed by GAP_CYCLES idle cycles.
//
// Ports
//   clk_100M         in   1  sole clock (BRAM domain), rising edge
//   reset            in   1  asynchronous, active-high, clears all state
//   transmit         in   1  scan request; rising edge starts, low aborts
//   sample_addr      out 11  BRAM read address (= step index), held between fetches
//   sample_data      in  16  BRAM read data in mm, valid one cycle after address
//   data_enable_step out 28  {data[15:0], enable, step[10:0]}, all registered
//   busy             out  1  high from scan start through the done cycle
//   done             out  1  one-cycle pulse after the last step's gap
module rangefinder_step_streamer
  import rangefinder_pkg::*;
#(
  parameter int STEP_FIRST = DEF_STEP_FIRST,
  parameter int STEP_LAST  = DEF_STEP_LAST,
  parameter int GAP_CYCLES = 4,
  parameter int MIN_MM     = 20,
  parameter int MAX_MM     = 5600
) (
  input  logic        clk_100M,
  input  logic        reset,
  input  logic        transmit,
  output logic [10:0] sample_addr,
  input  logic [15:0] sample_data,
  output logic [27:0] data_enable_step,
  output logic        busy,
  output logic        done
);

  localparam int DATA_W = DES_DATA_MSB - DES_DATA_LSB + 1;
  localparam int STEP_W = DES_STEP_MSB + 1;

  localparam logic [DATA_W-1:0] MIN_V   = DATA_W'(MIN_MM);
  localparam logic [DATA_W-1:0] MAX_V   = DATA_W'(MAX_MM);
  localparam logic [STEP_W-1:0] FIRST_V = STEP_W'(STEP_FIRST);
  localparam logic [STEP_W-1:0] LAST_V  = STEP_W'(STEP_LAST);
  localparam logic [7:0]        GAP_V   = 8'(GAP_CYCLES - 1);

  if (STEP_FIRST < 0 || STEP_LAST < STEP_FIRST || STEP_LAST > 2047) begin : g_bad_steps
    $error("rangefinder_step_streamer: need 0 <= STEP_FIRST <= STEP_LAST <= 2047");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("rangefinder_step_streamer: GAP_CYCLES must be 1..255");
  end

  // Out-of-range readings are reported as 0 so the map builder treats them
  // as invalid; comparisons are unsigned.
  function automatic logic [DATA_W-1:0] range_filter(input logic [DATA_W-1:0] mm);
    if (mm < MIN_V || mm > MAX_V) return '0;
    return mm;
  endfunction

  streamer_state_t   state, state_next;
  logic              tx_q;
  logic [STEP_W-1:0] step_cnt;
  logic [7:0]        gap_cnt;
  logic [DATA_W-1:0] data_q;
  logic              en_q;
  logic [STEP_W-1:0] step_q;
  logic              start;
  logic              gap_end;
  logic              last_step;

  assign start     = transmit & ~tx_q;
  assign gap_end   = (gap_cnt == '0);
  assign last_step = (step_cnt == LAST_V);

  // State register
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state and status outputs; a low transmit aborts every state except
  // IDLE and DONE (a PRESENT strobe still goes out before the abort lands).
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_FETCH;
      end
      S_FETCH:   state_next = transmit ? S_WAIT    : S_IDLE;
      S_WAIT:    state_next = transmit ? S_PRESENT : S_IDLE;
      S_PRESENT: state_next = transmit ? S_GAP     : S_IDLE;
      S_GAP: begin
        if (!transmit)    state_next = S_IDLE;
        else if (gap_end) state_next = last_step ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Counters, BRAM address and output word; enable is a one-cycle strobe
  // because it is cleared on every edge that is not leaving PRESENT.
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      tx_q        <= 1'b0;
      step_cnt    <= '0;
      gap_cnt     <= '0;
      sample_addr <= '0;
      data_q      <= '0;
      en_q        <= 1'b0;
      step_q      <= '0;
    end else begin
      tx_q <= transmit;
      en_q <= 1'b0;
      case (state)
        S_IDLE:  if (start) step_cnt <= FIRST_V;
        S_FETCH: sample_addr <= step_cnt;
        S_PRESENT: begin
          data_q  <= range_filter(sample_data);
          step_q  <= step_cnt;
          en_q    <= 1'b1;
          gap_cnt <= GAP_V;
        end
        S_GAP: begin
          if (!gap_end)                  gap_cnt  <= gap_cnt - 1'b1;
          else if (state_next == S_FETCH) step_cnt <= step_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_enable_step[DES_DATA_MSB:DES_DATA_LSB] = data_q;
  assign data_enable_step[DES_ENABLE]                = en_q;
  assign data_enable_step[DES_STEP_MSB:0]            = step_q;

endmodule

// File: tb/tb_rangefinder_step_streamer.sv
// Testbench for rangefinder_step_streamer: a default-parameter instance and a
// single-step instance (STEP_FIRST = STEP_LAST = 10, GAP_CYCLES = 1), each fed
// by a registered-read BRAM model.
module tb_rangefinder_step_streamer;

  localparam int A_FIRST = 44;
  localparam int A_LAST  = 725;
  localparam int A_GAP   = 4;
  localparam int A_PER   = 3 + A_GAP;
  localparam int A_N     = A_LAST - A_FIRST + 1;
  localparam int B_STEP  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntests = 0;
  int nfail  = 0;

  // ---------------- DUT A (defaults) ----------------
  logic        rst_a = 1'b0, tx_a = 1'b0;
  logic [10:0] addr_a;
  logic [15:0] rd_a;
  logic [27:0] des_a;
  logic        busy_a, done_a;
  logic [15:0] mem_a [0:2047];
  always @(posedge clk) rd_a <= mem_a[addr_a];

  rangefinder_step_streamer dut_a (
    .clk_100M(clk), .reset(rst_a), .transmit(tx_a), .sample_addr(addr_a),
    .sample_data(rd_a), .data_enable_step(des_a), .busy(busy_a), .done(done_a)
  );

  // ---------------- DUT B (single step) ----------------
  logic        rst_b = 1'b0, tx_b = 1'b0;
  logic [10:0] addr_b;
  logic [15:0] rd_b;
  logic [27:0] des_b;
  logic        busy_b, done_b;
  logic [15:0] mem_b [0:2047];
  always @(posedge clk) rd_b <= mem_b[addr_b];

  rangefinder_step_streamer #(
    .STEP_FIRST(B_STEP), .STEP_LAST(B_STEP), .GAP_CYCLES(1)
  ) dut_b (
    .clk_100M(clk), .reset(rst_b), .transmit(tx_b), .sample_addr(addr_b),
    .sample_data(rd_b), .data_enable_step(des_b), .busy(busy_b), .done(done_b)
  );

  // ---------------- Monitors ----------------
  int sa_cyc[$], sa_step[$], sa_data[$], da_cyc[$];
  int busy_cnt_a = 0, viol_a = 0;
  logic        en_prev_a = 1'b0;
  logic [26:0] flds_prev_a = '0;

  always @(negedge clk) begin
    if (!rst_a) begin
      if (des_a[11]) begin
        sa_cyc.push_back(cyc);
        sa_step.push_back(int'(des_a[10:0]));
        sa_data.push_back(int'(des_a[27:12]));
        if (en_prev_a) viol_a++;
      end else if ({des_a[27:12], des_a[10:0]} !== flds_prev_a) begin
        viol_a++;
      end
      if (done_a) da_cyc.push_back(cyc);
      if (busy_a) busy_cnt_a++;
    end
    en_prev_a   = des_a[11];
    flds_prev_a = {des_a[27:12], des_a[10:0]};
  end

  int sb_cyc[$], sb_step[$], sb_data[$], db_cyc[$];
  int busy_cnt_b = 0;
  always @(negedge clk) begin
    if (!rst_b) begin
      if (des_b[11]) begin
        sb_cyc.push_back(cyc);
        sb_step.push_back(int'(des_b[10:0]));
        sb_data.push_back(int'(des_b[27:12]));
      end
      if (done_b) db_cyc.push_back(cyc);
      if (busy_b) busy_cnt_b++;
    end
  end

  // ---------------- Reference rules ----------------
  function automatic int filt(input int v);
    return (v < 20 || v > 5600) ? 0 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_a();
    sa_cyc.delete(); sa_step.delete(); sa_data.delete(); da_cyc.delete();
    busy_cnt_a = 0; viol_a = 0;
  endtask

  task automatic start_a(output int t0);
    @(posedge clk); #1;
    tx_a = 1'b1;
    t0   = cyc + 1;
  endtask

  task automatic start_b(output int t0);
    @(posedge clk); #1;
    tx_b = 1'b1;
    t0   = cyc + 1;
  endtask

  task automatic wait_done_a(input int budget, input string tag);
    int n0 = da_cyc.size();
    int i  = 0;
    while (da_cyc.size() == n0 && i < budget) begin
      @(negedge clk); #1; i++;
    end
    chk({tag, "_done_seen"}, (da_cyc.size() > n0), 1);
  endtask

  task automatic wait_done_b(input int budget, input string tag);
    int n0 = db_cyc.size();
    int i  = 0;
    while (db_cyc.size() == n0 && i < budget) begin
      @(negedge clk); #1; i++;
    end
    chk({tag, "_done_seen"}, (db_cyc.size() > n0), 1);
  endtask

  task automatic wait_strobes_a(input int n, input int budget, input string tag);
    int i = 0;
    while (sa_step.size() < n && i < budget) begin
      @(negedge clk); #1; i++;
    end
    chk({tag, "_strobes_reached"}, (sa_step.size() >= n), 1);
  endtask

  // Whole-scan expectation: strobe k carries step FIRST+k, the filtered
  // BRAM word, at t0+3+k*period; done follows the last strobe by the gap.
  task automatic check_full_scan_a(input int t0, input string tag);
    int m;
    chk({tag, "_strobes"}, sa_step.size(), A_N);
    m = (sa_step.size() < A_N) ? sa_step.size() : A_N;
    for (int k = 0; k < m; k++) begin
      chk({tag, "_cyc"},  sa_cyc[k],  t0 + 3 + k * A_PER);
      chk({tag, "_step"}, sa_step[k], A_FIRST + k);
      chk({tag, "_data"}, sa_data[k], filt(int'(mem_a[A_FIRST + k])));
    end
    chk({tag, "_dones"}, da_cyc.size(), 1);
    if (da_cyc.size() > 0)
      chk({tag, "_done_cyc"}, da_cyc[0], t0 + 3 + (A_N - 1) * A_PER + A_GAP);
    chk({tag, "_busy_cycles"}, busy_cnt_a, 3 + (A_N - 1) * A_PER + A_GAP + 1);
    chk({tag, "_strobe_rules"}, viol_a, 0);
  endtask

  // ---------------- Directed sequence ----------------
  initial begin
    int t0, tb0, nd, r;

    for (int s = 0; s < 2048; s++) begin
      mem_a[s] = 16'(s * 4);
      mem_b[s] = 16'h0;
    end
    mem_b[B_STEP] = 16'($urandom_range(0, 7000));

    // Reset state
    #1; rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_des_a",  des_a,  0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_des_b",  des_b,  0);
    chk("rst_busy_b", busy_b, 0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(posedge clk);

    // Scan 1: data = step*4
    clr_a();
    start_a(t0);
    wait_done_a(6000, "scan1");
    check_full_scan_a(t0, "scan1");
    if (sa_step.size() > 0) begin
      chk("scan1_first_step", sa_step[0], 44);
      chk("scan1_first_data", sa_data[0], 176);
      chk("scan1_last_step", sa_step[sa_step.size() - 1], 725);
      chk("scan1_last_data", sa_data[sa_data.size() - 1], 2900);
    end

    // transmit held high after done: no rescan
    repeat (30) @(negedge clk);
    #1;
    chk("hold_no_rescan_strobes", sa_step.size(), A_N);
    chk("hold_no_rescan_dones",   da_cyc.size(), 1);
    chk("hold_idle_busy",         busy_a, 0);
    @(posedge clk); #1; tx_a = 1'b0;
    @(posedge clk);

    // Scan 2: abort on the 100th strobe
    clr_a();
    start_a(t0);
    wait_strobes_a(100, 1500, "abort");
    chk("abort_strobe_cyc", (sa_cyc.size() >= 100) ? sa_cyc[99] : -1, t0 + 3 + 99 * A_PER);
    tx_a = 1'b0;
    @(negedge clk); #1;
    chk("abort_busy_low", busy_a, 0);
    chk("abort_enable_low", des_a[11], 0);
    chk("abort_step_held", des_a[10:0], A_FIRST + 99);
    chk("abort_data_held", des_a[27:12], filt(int'(mem_a[A_FIRST + 99])));
    repeat (40) @(negedge clk);
    #1;
    chk("abort_no_done", da_cyc.size(), 0);
    chk("abort_no_more_strobes", sa_step.size(), 100);
    chk("abort_strobe_rules", viol_a, 0);

    // Scan 3: restart, then asynchronous reset inside a gap
    clr_a();
    start_a(t0);
    wait_strobes_a(3, 200, "restart");
    chk("restart_first_step", (sa_step.size() > 0) ? sa_step[0] : -1, A_FIRST);
    chk("restart_first_cyc",  (sa_cyc.size() > 0) ? sa_cyc[0] : -1, t0 + 3);
    @(posedge clk); #2;
    rst_a = 1'b1;
    #1;
    chk("async_rst_des",  des_a,  0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_addr", addr_a, 0);
    tx_a = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("post_rst_idle_busy", busy_a, 0);
    chk("post_rst_no_strobes", sa_step.size(), 3);

    // Scan 4: random BRAM contents with filter boundaries at steps 44..47
    for (int s = 0; s < 2048; s++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      mem_a[s] = 16'($urandom_range(0, 19));
      else if (r == 1) mem_a[s] = 16'($urandom_range(5601, 65535));
      else             mem_a[s] = 16'($urandom_range(20, 5600));
    end
    mem_a[44] = 16'd19;
    mem_a[45] = 16'd20;
    mem_a[46] = 16'd5600;
    mem_a[47] = 16'd5601;
    clr_a();
    start_a(t0);
    wait_done_a(6000, "scan4");
    check_full_scan_a(t0, "scan4");
    if (sa_data.size() >= 4) begin
      chk("bound_19",   sa_data[0], 0);
      chk("bound_20",   sa_data[1], 20);
      chk("bound_5600", sa_data[2], 5600);
      chk("bound_5601", sa_data[3], 0);
    end
    @(posedge clk); #1; tx_a = 1'b0;

    // DUT B: single step, gap 1; a sub-cycle glitch on transmit during busy
    start_b(tb0);
    @(posedge clk); #2; tx_b = 1'b0;
    #2; tx_b = 1'b1;
    wait_done_b(50, "single");
    chk("single_strobes", sb_step.size(), 1);
    chk("single_step", (sb_step.size() > 0) ? sb_step[0] : -1, B_STEP);
    chk("single_cyc",  (sb_cyc.size() > 0) ? sb_cyc[0] : -1, tb0 + 3);
    chk("single_data", (sb_data.size() > 0) ? sb_data[0] : -1, filt(int'(mem_b[B_STEP])));
    chk("single_done_cyc", (db_cyc.size() > 0) ? db_cyc[0] : -1, tb0 + 4);
    chk("single_busy_cycles", busy_cnt_b, 5);
    repeat (10) @(negedge clk);
    #1;
    chk("single_hold_strobes", sb_step.size(), 1);
    chk("single_hold_dones", db_cyc.size(), 1);
    @(posedge clk); #1; tx_b = 1'b0;
    @(posedge clk);
    start_b(tb0);
    nd = db_cyc.size();
    wait_done_b(50, "single2");
    chk("single2_strobes", sb_step.size(), 2);
    chk("single2_cyc", (sb_cyc.size() > 1) ? sb_cyc[1] : -1, tb0 + 3);
    chk("single2_done_cyc", (db_cyc.size() > nd) ? db_cyc[nd] : -1, tb0 + 4);
    tx_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
